// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: instruction-fetch and next-PC stage for the single-cycle
// RISC-V core. Holds the architectural PC, fetches one instruction word per
// FETCH/EXEC round trip over a valid handshake, resolves the next PC on
// commit, and parks in TRAP on a misaligned control-transfer target.

module fetch_pc_unit #(
   parameter int                XLEN     = 32,
   parameter logic [XLEN-1:0]   RESET_PC = '0
) (
   input  logic             clk,
   input  logic             rst,

   // instruction memory handshake
   output logic             imem_req,
   output logic [XLEN-1:0]  imem_addr,
   input  logic             imem_valid,
   input  logic [31:0]      imem_rdata,

   // instruction presented to the decode controller
   output logic [31:0]      instr,
   output logic             instr_valid,
   output logic [XLEN-1:0]  pc,
   output logic [XLEN-1:0]  pc_plus4,

   // next-PC resolution inputs
   input  logic             commit,
   input  logic             jal,
   input  logic             jalr,
   input  logic             branch,
   input  logic [2:0]       funct3,
   input  logic             zero,
   input  logic             neg,
   input  logic [XLEN-1:0]  imm_ext,
   input  logic [XLEN-1:0]  alu_result,

   // status
   output logic             trap,
   output logic [31:0]      instret
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      EXEC  = 2'd1,
      TRAP  = 2'd2
   } state_t;

   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;
   localparam logic [2:0] F3_BLT = 3'b100;
   localparam logic [2:0] F3_BGE = 3'b101;

   localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);
   localparam logic [XLEN-1:0] BIT0_CLR = ~XLEN'(1);

   state_t            state;
   state_t            state_next;

   logic              branch_taken;
   logic [XLEN-1:0]   branch_target;
   logic [XLEN-1:0]   jalr_target;
   logic [XLEN-1:0]   next_pc;
   logic              next_pc_misaligned;
   logic              retire;
   logic              load_instr;

   // ------------------------------------------------------------------
   // Next-PC datapath
   // ------------------------------------------------------------------

   // Branch condition decode from funct3 and the ALU flags.
   // NOTE: every combinational output gets a default before the case so no
   // path leaves it unassigned; otherwise synthesis infers a latch.
   always_comb begin
      branch_taken = 1'b0;
      case (funct3)
         F3_BEQ:  branch_taken = zero;
         F3_BNE:  branch_taken = !zero;
         F3_BLT:  branch_taken = neg;
         F3_BGE:  branch_taken = !neg;
         default: branch_taken = 1'b0;
      endcase
   end

   // All adds wrap silently modulo 2^XLEN.
   assign pc_plus4      = pc + PC_STEP;
   assign branch_target = pc + imm_ext;

   // jalr clears bit 0 before the alignment check, so only bit 1 can trap.
   assign jalr_target   = alu_result & BIT0_CLR;

   // Target select: jalr dominates jal, jal/taken-branch dominate fall-through.
   always_comb begin
      next_pc = pc_plus4;
      if (jalr) begin
         next_pc = jalr_target;
      end else if (jal || (branch && branch_taken)) begin
         next_pc = branch_target;
      end
   end

   assign next_pc_misaligned = |next_pc[1:0];

   // An instruction retires only on a commit seen in EXEC; commit is
   // ignored in FETCH and TRAP.
   assign retire     = (state == EXEC) && commit;

   // A memory response is only consumed in FETCH; in EXEC it is dropped,
   // which also makes commit win when both arrive in the same cycle.
   assign load_instr = (state == FETCH) && imem_valid;

   // ------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------

   // State register.
   // NOTE: sequential state is always written with non-blocking assignments
   // so every flop samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= FETCH;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: FETCH waits (unbounded) for the memory, EXEC waits
   // for commit, TRAP is sticky until reset.
   always_comb begin
      state_next = state;
      case (state)
         FETCH: begin
            if (imem_valid) begin
               state_next = EXEC;
            end
         end
         EXEC: begin
            if (commit) begin
               state_next = next_pc_misaligned ? TRAP : FETCH;
            end
         end
         TRAP:    state_next = TRAP;
         default: state_next = FETCH;
      endcase
   end

   // Moore outputs; the fetch request is held off while reset is asserted
   // so the first request appears only once reset has been released.
   always_comb begin
      imem_req    = 1'b0;
      instr_valid = 1'b0;
      case (state)
         FETCH:   imem_req    = !rst;
         EXEC:    instr_valid = 1'b1;
         default: begin
            imem_req    = 1'b0;
            instr_valid = 1'b0;
         end
      endcase
   end

   // The fetch address is the architectural PC, stable throughout FETCH.
   assign imem_addr = pc;

   // ------------------------------------------------------------------
   // Architectural registers
   // ------------------------------------------------------------------

   // PC: advances only on an aligned retire; a misaligned target leaves it
   // pointing at the faulting instruction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc <= RESET_PC;
      end else if (retire && !next_pc_misaligned) begin
         pc <= next_pc;
      end
   end

   // Instruction latch: captured on the handshake, held stable through EXEC.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr <= '0;
      end else if (load_instr) begin
         instr <= imem_rdata;
      end
   end

   // Sticky trap flag, set by a retire whose target is misaligned.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         trap <= 1'b0;
      end else if (retire && next_pc_misaligned) begin
         trap <= 1'b1;
      end
   end

   // Retired-instruction counter; the trapping instruction still counts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instret <= '0;
      end else if (retire) begin
         instret <= instret + 32'd1;
      end
   end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed, table-driven bench for fetch_pc_unit.
// Inputs change 1 ns after the rising edge; outputs are sampled there too.

module tb_fetch_pc_unit;

   localparam int XLEN = 32;

   logic             clk = 1'b0;
   logic             rst;
   logic             imem_req;
   logic [XLEN-1:0]  imem_addr;
   logic             imem_valid;
   logic [31:0]      imem_rdata;
   logic [31:0]      instr;
   logic             instr_valid;
   logic [XLEN-1:0]  pc;
   logic [XLEN-1:0]  pc_plus4;
   logic             commit;
   logic             jal;
   logic             jalr;
   logic             branch;
   logic [2:0]       funct3;
   logic             zero;
   logic             neg;
   logic [XLEN-1:0]  imm_ext;
   logic [XLEN-1:0]  alu_result;
   logic             trap;
   logic [31:0]      instret;

   int errors = 0;
   int checks = 0;

   fetch_pc_unit #(.XLEN(XLEN), .RESET_PC(32'h0000_0000)) dut (
      .clk        (clk),
      .rst        (rst),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_valid (imem_valid),
      .imem_rdata (imem_rdata),
      .instr      (instr),
      .instr_valid(instr_valid),
      .pc         (pc),
      .pc_plus4   (pc_plus4),
      .commit     (commit),
      .jal        (jal),
      .jalr       (jalr),
      .branch     (branch),
      .funct3     (funct3),
      .zero       (zero),
      .neg        (neg),
      .imm_ext    (imm_ext),
      .alu_result (alu_result),
      .trap       (trap),
      .instret    (instret)
   );

   always #5 clk = ~clk;

   typedef struct {
      string        name;
      logic [31:0]  start_pc;
      logic         jal;
      logic         jalr;
      logic         branch;
      logic [2:0]   funct3;
      logic         zero;
      logic         neg;
      logic [31:0]  imm;
      logic [31:0]  alu;
      logic [31:0]  exp_pc;
      logic         exp_trap;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ctrl();
      commit     = 1'b0;
      jal        = 1'b0;
      jalr       = 1'b0;
      branch     = 1'b0;
      funct3     = 3'b000;
      zero       = 1'b0;
      neg        = 1'b0;
      imm_ext    = '0;
      alu_result = '0;
   endtask

   // Reset, release, and check the reset state.
   task automatic do_reset();
      rst        = 1'b1;
      imem_valid = 1'b0;
      imem_rdata = '0;
      clear_ctrl();
      tick();
      tick();
      rst = 1'b0;
      #1;
      check("rst_pc", pc, 32'h0);
      check("rst_instr", instr, 32'h0);
      check("rst_instr_valid", instr_valid, 1'b0);
      check("rst_trap", trap, 1'b0);
      check("rst_instret", instret, 32'h0);
      check("rst_imem_req", imem_req, 1'b1);
   endtask

   // Memory model: hold off for 'waits' cycles, then return 'data' once.
   task automatic fetch(input int waits, input logic [31:0] data, input logic [31:0] exp_addr);
      for (int i = 0; i < waits; i++) begin
         check("fetch_wait_req", imem_req, 1'b1);
         check("fetch_wait_addr", imem_addr, exp_addr);
         check("fetch_wait_instr_valid", instr_valid, 1'b0);
         tick();
      end
      check("fetch_req", imem_req, 1'b1);
      check("fetch_addr", imem_addr, exp_addr);
      imem_valid = 1'b1;
      imem_rdata = data;
      tick();
      imem_valid = 1'b0;
      imem_rdata = '0;
      check("fetch_instr_valid", instr_valid, 1'b1);
      check("fetch_instr", instr, data);
      check("exec_imem_req", imem_req, 1'b0);
   endtask

   task automatic commit_with(input logic j, input logic jr, input logic b, input logic [2:0] f3,
                              input logic z, input logic n, input logic [31:0] imm,
                              input logic [31:0] alu);
      jal        = j;
      jalr       = jr;
      branch     = b;
      funct3     = f3;
      zero       = z;
      neg        = n;
      imm_ext    = imm;
      alu_result = alu;
      commit     = 1'b1;
      tick();
      clear_ctrl();
   endtask

   // Reach an arbitrary aligned PC: one jal from RESET_PC, then wait in FETCH.
   task automatic goto_pc(input logic [31:0] target);
      do_reset();
      fetch(0, 32'h0000_006F, 32'h0);
      commit_with(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, target, 32'h0);
      check("goto_pc", pc, target);
   endtask

   vec_t vecs[17] = '{
      '{"beq_taken",     32'h10, 0, 0, 1, 3'b000, 1, 0, 32'hFFFF_FFF8, 32'h0,   32'h08, 0},
      '{"beq_not",       32'h10, 0, 0, 1, 3'b000, 0, 0, 32'hFFFF_FFF8, 32'h0,   32'h14, 0},
      '{"bne_taken",     32'h10, 0, 0, 1, 3'b001, 0, 0, 32'h8,         32'h0,   32'h18, 0},
      '{"bne_not",       32'h10, 0, 0, 1, 3'b001, 1, 0, 32'h8,         32'h0,   32'h14, 0},
      '{"blt_taken",     32'h10, 0, 0, 1, 3'b100, 0, 1, 32'hC,         32'h0,   32'h1C, 0},
      '{"blt_not",       32'h10, 0, 0, 1, 3'b100, 0, 0, 32'hC,         32'h0,   32'h14, 0},
      '{"bge_taken",     32'h10, 0, 0, 1, 3'b101, 0, 0, 32'h20,        32'h0,   32'h30, 0},
      '{"bge_not",       32'h10, 0, 0, 1, 3'b101, 0, 1, 32'h20,        32'h0,   32'h14, 0},
      '{"f3_010_never",  32'h10, 0, 0, 1, 3'b010, 1, 1, 32'h20,        32'h0,   32'h14, 0},
      '{"no_branch",     32'h10, 0, 0, 0, 3'b000, 1, 0, 32'h20,        32'h0,   32'h14, 0},
      '{"jalr_ok",       32'h0,  0, 1, 0, 3'b000, 0, 0, 32'h0,         32'h101, 32'h100, 0},
      '{"jal_and_br",    32'h40, 1, 0, 1, 3'b000, 0, 0, 32'h20,        32'h0,   32'h60, 0},
      '{"jalr_over_jal", 32'h40, 1, 1, 0, 3'b000, 0, 0, 32'h20,        32'h201, 32'h200, 0},
      '{"pc_wrap",       32'hFFFF_FFFC, 0, 0, 0, 3'b000, 0, 0, 32'h0,  32'h0,   32'h0,  0},
      '{"jalr_trap",     32'h8,  0, 1, 0, 3'b000, 0, 0, 32'h0,         32'h102, 32'h8,  1},
      '{"jal_misalign",  32'h10, 1, 0, 0, 3'b000, 0, 0, 32'h2,         32'h0,   32'h10, 1},
      '{"jalr_bit1_0",   32'h10, 0, 1, 0, 3'b000, 0, 0, 32'h0,         32'h103, 32'h10, 1}
   };

   initial begin
      rst        = 1'b1;
      imem_valid = 1'b0;
      imem_rdata = '0;
      clear_ctrl();

      // Zero-wait sequential run: pc 0,4,8, commit one cycle after instr_valid.
      do_reset();
      for (int k = 0; k < 3; k++) begin
         check("seq_pc", pc, 32'(4 * k));
         fetch(0, 32'h0000_0013, 32'(4 * k));
         check("seq_pc_plus4", pc_plus4, 32'(4 * k + 4));
         tick();
         check("seq_exec_req", imem_req, 1'b0);
         check("seq_exec_valid", instr_valid, 1'b1);
         commit_with(0, 0, 0, 3'b000, 0, 0, 32'h0, 32'h0);
         check("seq_next_pc", pc, 32'(4 * k + 4));
      end
      check("seq_instret", instret, 32'd3);

      // Three wait states at pc=0: address held for four cycles.
      do_reset();
      fetch(3, 32'hDEAD_BEEF, 32'h0);

      // Commit during FETCH is ignored.
      do_reset();
      jal     = 1'b1;
      imm_ext = 32'h40;
      commit  = 1'b1;
      tick();
      tick();
      check("fetch_commit_pc", pc, 32'h0);
      check("fetch_commit_instret", instret, 32'h0);
      check("fetch_commit_valid", instr_valid, 1'b0);
      clear_ctrl();
      fetch(0, 32'h1111_1111, 32'h0);

      // Commit and imem_valid together in EXEC: commit wins, response dropped.
      imem_valid = 1'b1;
      imem_rdata = 32'h2222_2222;
      commit_with(0, 0, 0, 3'b000, 0, 0, 32'h0, 32'h0);
      imem_valid = 1'b0;
      imem_rdata = '0;
      check("race_pc", pc, 32'h4);
      check("race_instr_valid", instr_valid, 1'b0);
      check("race_instr", instr, 32'h1111_1111);
      check("race_req", imem_req, 1'b1);
      check("race_instret", instret, 32'd1);

      // Table-driven next-PC vectors.
      for (int v = 0; v < 17; v++) begin
         goto_pc(vecs[v].start_pc);
         fetch(0, 32'h0000_0063, vecs[v].start_pc);
         commit_with(vecs[v].jal, vecs[v].jalr, vecs[v].branch, vecs[v].funct3,
                     vecs[v].zero, vecs[v].neg, vecs[v].imm, vecs[v].alu);
         check({vecs[v].name, "_pc"}, pc, vecs[v].exp_pc);
         check({vecs[v].name, "_trap"}, trap, vecs[v].exp_trap);
         check({vecs[v].name, "_instret"}, instret, 32'd2);
         check({vecs[v].name, "_valid"}, instr_valid, 1'b0);
         check({vecs[v].name, "_req"}, imem_req, !vecs[v].exp_trap);
         if (vecs[v].exp_trap) begin
            // TRAP is sticky: memory responses and commits have no effect.
            imem_valid = 1'b1;
            imem_rdata = 32'h0000_0013;
            jal        = 1'b1;
            imm_ext    = 32'h4;
            commit     = 1'b1;
            for (int c = 0; c < 3; c++) begin
               tick();
               check({vecs[v].name, "_sticky_req"}, imem_req, 1'b0);
               check({vecs[v].name, "_sticky_trap"}, trap, 1'b1);
               check({vecs[v].name, "_sticky_valid"}, instr_valid, 1'b0);
               check({vecs[v].name, "_sticky_pc"}, pc, vecs[v].exp_pc);
               check({vecs[v].name, "_sticky_instret"}, instret, 32'd2);
            end
            imem_valid = 1'b0;
            imem_rdata = '0;
            clear_ctrl();
         end
      end

      // Asynchronous reset out of TRAP (left by the last vector).
      rst = 1'b1;
      #1;
      check("trap_rst_trap", trap, 1'b0);
      check("trap_rst_pc", pc, 32'h0);

      // Asynchronous reset in EXEC with instret=5.
      do_reset();
      for (int k = 0; k < 5; k++) begin
         fetch(0, 32'h0000_0013, 32'(4 * k));
         commit_with(0, 0, 0, 3'b000, 0, 0, 32'h0, 32'h0);
      end
      fetch(0, 32'h0000_0013, 32'h14);
      check("pre_rst_instret", instret, 32'd5);
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_valid", instr_valid, 1'b0);
      check("mid_rst_pc", pc, 32'h0);
      check("mid_rst_instret", instret, 32'h0);
      check("mid_rst_trap", trap, 1'b0);
      check("mid_rst_instr", instr, 32'h0);
      tick();
      rst = 1'b0;
      #1;
      check("post_rst_req", imem_req, 1'b1);
      check("post_rst_addr", imem_addr, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
Instruction-fetch and next-PC stage that sits directly upstream of the main decode controller in the single-cycle RISC-V core. It holds the architectural PC and fetches the instruction word from instruction memory through a valid handshake. It presents the instruction (opcode field feeds the main controller) until the datapath signals commit. It then resolves the next PC from the controller's jal/jalr/branch outputs and the ALU zero/neg flags.

Parameters:
XLEN, 32, datapath/PC width in bits
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  asynchronous, active-high reset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  XLEN  fetch address (always equals pc)
imem_valid  in  1  instruction memory has returned data this cycle
imem_rdata  in  32  returned instruction word
instr  out  32  latched instruction (instr[6:0] drives controller op)
instr_valid  out  1  instr is valid and awaiting execution
pc  out  XLEN  current PC
pc_plus4  out  XLEN  pc + 4 (for jal/jalr link writeback)
commit  in  1  datapath has finished the current instruction
jal  in  1  from controller
jalr  in  1  from controller
branch  in  1  from controller
funct3  in  3  instr[14:12] branch condition select
zero  in  1  ALU result zero flag
neg  in  1  ALU result negative flag
imm_ext  in  XLEN  sign-extended immediate
alu_result  in  XLEN  ALU output (jalr target)
trap  out  1  sticky misaligned-target flag
instret  out  32  retired-instruction counter

Behaviour:
- Reset (async, immediate): state=FETCH, pc=RESET_PC, instr=0, instr_valid=0, trap=0, instret=0; imem_req=1 from the first clock after rst deasserts.
- States: FETCH, EXEC, TRAP.
- FETCH: imem_req=1, imem_addr=pc held stable. On the clock edge where imem_valid=1: instr<=imem_rdata, go EXEC. Wait states are unbounded. Minimum latency is 1 cycle FETCH->EXEC.
- EXEC: instr_valid=1, imem_req=0, instr stable. imem_valid is ignored. On the edge with commit=1: compute next_pc, instret<=instret+1 (wraps at 2^32).
  - If next_pc[1:0]==0: pc<=next_pc, go FETCH.
  - Else: pc unchanged, trap<=1, go TRAP.
- TRAP: imem_req=0, instr_valid=0, trap=1. Exit only via rst.
- commit is ignored in FETCH and TRAP.
- Branch taken (combinational, by funct3):
  - 000 beq: zero
  - 001 bne: !zero
  - 100 blt: neg
  - 101 bge: !neg
  - any other value: not taken
- next_pc priority:
  - jalr: {alu_result[XLEN-1:1],1'b0}
  - else jal, or (branch && taken): pc+imm_ext
  - else: pc+4
- All PC arithmetic is modulo 2^XLEN; wrap past 32'hFFFF_FFFC is silent.
- The misalignment check applies after jalr bit-0 clearing, so only bit 1 can trigger trap on jalr.
- pc_plus4 is combinational pc+4, valid in every state.
- Simultaneous commit and imem_valid in EXEC: commit wins; imem_valid is dropped.
- rst asserted mid-FETCH (memory response pending) aborts the fetch. A late imem_valid arriving after reset is consumed as the response to the new RESET_PC request; the memory model must not issue one.

Test Plan:
- Reset, zero-wait memory returning 32'h0000_0013, commit one cycle after instr_valid -> pc sequence 0,4,8; instret=3 after three commits; imem_req low during every EXEC cycle.
- Memory inserts 3 wait cycles at pc=0 -> imem_addr=0 held for 4 cycles; instr_valid rises the cycle after imem_valid; instr=imem_rdata.
- pc=32'h10, branch=1, funct3=000, zero=1, imm_ext=32'hFFFF_FFF8, commit -> pc=32'h08. Same with zero=0 -> pc=32'h14. funct3=101, neg=0 -> taken.
- jalr=1, alu_result=32'h0000_0101, commit -> pc=32'h100, trap=0. jalr with alu_result=32'h0000_0102 -> trap=1, pc unchanged, imem_req=0 until reset.
- jal=1 and branch=1 together, imm_ext=32'h20 at pc=32'h40 -> pc=32'h60. jalr asserted with jal -> jalr target used.
- rst asserted in EXEC with instret=5 -> same cycle: instr_valid=0, pc=RESET_PC, instret=0, trap=0. Commit during FETCH -> no PC or instret change.
